// File: rtl/sd_buf_arbiter.sv
// Round-robin arbiter sharing one single-port sector buffer RAM between the
// SD card engine and a host requester; one word per req/ack handshake.
module sd_buf_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sd_req,
  input  logic [ADDR_W-1:0] i_sd_addr,
  input  logic              i_sd_wr_nrd,
  input  logic [DATA_W-1:0] i_sd_data,
  output logic [DATA_W-1:0] o_sd_data,
  output logic              o_sd_ack,
  input  logic              i_host_req,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic              i_host_wr_nrd,
  input  logic [DATA_W-1:0] i_host_data,
  output logic [DATA_W-1:0] o_host_data,
  output logic              o_host_ack,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  localparam logic SEL_SD   = 1'b0;
  localparam logic SEL_HOST = 1'b1;

  state_t              state_q, state_d;
  logic                sel_q, sel_d;
  logic                last_q, last_d;
  logic                wr_q, wr_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   sd_data_q, sd_data_d;
  logic [DATA_W-1:0]   host_data_q, host_data_d;
  logic                sd_ack_q, sd_ack_d;
  logic                host_ack_q, host_ack_d;
  logic                busy_q, busy_d;
  logic                grant_host;

  // On a tie the port that was not granted last wins.
  assign grant_host = i_host_req & (~i_sd_req | (last_q == SEL_SD));

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    wr_d        = wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    sd_data_d   = sd_data_q;
    host_data_d = host_data_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    sd_ack_d    = 1'b0;
    host_ack_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_sd_req || i_host_req) begin
          sel_d       = grant_host;
          wr_d        = grant_host ? i_host_wr_nrd : i_sd_wr_nrd;
          mem_addr_d  = grant_host ? i_host_addr   : i_sd_addr;
          mem_wdata_d = grant_host ? i_host_data   : i_sd_data;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_host ? i_host_wr_nrd : i_sd_wr_nrd;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // RAM read data is valid during this cycle; writes leave port data alone.
        if (!wr_q) begin
          if (sel_q == SEL_HOST) host_data_d = i_mem_rdata;
          else                   sd_data_d   = i_mem_rdata;
        end
        if (sel_q == SEL_HOST) host_ack_d = 1'b1;
        else                   sd_ack_d   = 1'b1;
        state_d = S_ACK;
      end
      S_ACK: begin
        last_d  = sel_q;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= SEL_SD;
      last_q      <= SEL_HOST;
      wr_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      sd_data_q   <= '0;
      host_data_q <= '0;
      sd_ack_q    <= 1'b0;
      host_ack_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      wr_q        <= wr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      sd_data_q   <= sd_data_d;
      host_data_q <= host_data_d;
      sd_ack_q    <= sd_ack_d;
      host_ack_q  <= host_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign o_sd_data   = sd_data_q;
  assign o_sd_ack    = sd_ack_q;
  assign o_host_data = host_data_q;
  assign o_host_ack  = host_ack_q;
  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_busy      = busy_q;

endmodule

// File: doc/sd_buf_arbiter.md
# sd_buf_arbiter

Two-port arbiter that shares one single-port sector buffer RAM between the SD card engine (`sd_card_mem` memory-request side) and a host requester (CPU/VGA-side logic). Each requester issues single-word read or write accesses with a req/ack handshake. The arbiter serialises the accesses with round-robin priority, drives the RAM, and returns read data to the winning port.

## Interface
Parameters:
- `ADDR_W`, 9, buffer word-address width (512-entry sector buffer)
- `DATA_W`, 8, data width

Ports:
- `i_clk`  in  1  clock
- `i_rst_n`  in  1  reset, synchronous, active-low
- `i_sd_req`  in  1  SD engine access request, level
- `i_sd_addr`  in  ADDR_W  SD engine address
- `i_sd_wr_nrd`  in  1  SD engine access type: 1 = write, 0 = read
- `i_sd_data`  in  DATA_W  SD engine write data
- `o_sd_data`  out  DATA_W  read data to SD engine
- `o_sd_ack`  out  1  one-cycle completion pulse to SD engine
- `i_host_req`, `i_host_addr`, `i_host_wr_nrd`, `i_host_data`  in  1/ADDR_W/1/DATA_W  host request, same semantics as the SD engine port
- `o_host_data`  out  DATA_W  read data to host
- `o_host_ack`  out  1  one-cycle completion pulse to host
- `o_mem_en`  out  1  RAM enable
- `o_mem_we`  out  1  RAM write enable
- `o_mem_addr`  out  ADDR_W  RAM address
- `o_mem_wdata`  out  DATA_W  RAM write data
- `i_mem_rdata`  in  DATA_W  RAM read data, registered, 1-cycle latency after `o_mem_en`
- `o_busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK. All outputs are registered.
- IDLE: when no request is pending, stay in IDLE. Otherwise pick a winner, latch its addr/wr_nrd/data and a `sel` bit, then go to ISSUE.
- Round-robin: `last` bit records the most recently granted port. On simultaneous requests, grant the port that is not `last`. A single request is granted unconditionally. Reset value of `last` = host, so the SD engine wins the first tie.
- ISSUE: `o_mem_en`=1. `o_mem_we`=latched wr_nrd. Address and wdata come from the latch. Then go to WAIT.
- WAIT: `o_mem_en`=0 and `o_mem_we`=0. For reads, `i_mem_rdata` is captured into the selected port's data register at the end of WAIT. Then go to ACK.
- ACK: pulse the selected port's ack for exactly one cycle. Update `last`=sel. Go to IDLE. Requests are ignored in ACK.
- Writes never change `o_sd_data` or `o_host_data`.
- The non-selected port's data register and ack are never touched.
- Request-side rules:
  - Requester holds req, addr, wr_nrd and data stable from req assertion until it samples ack.
  - Requester deasserts req on the edge where it samples ack.
  - A req still high in the IDLE cycle after ACK is treated as a new request.
- Reset (synchronous, `i_rst_n`=0 sampled on an edge): next state IDLE. All outputs 0: `o_mem_en`, `o_mem_we`, `o_mem_addr`, `o_mem_wdata`, `o_sd_data`, `o_host_data`, both acks, `o_busy`. `last`=host.
- Reset mid-operation:
  - A write whose ISSUE cycle ended before the reset edge is committed.
  - A write in ISSUE on the reset edge itself is also committed, because the RAM samples `o_mem_we` on that same edge.
  - No ack is issued for an aborted access. The requester must re-request.

## Timing
- Request sampled at edge E0 (end of IDLE cycle) -> ISSUE is cycle 1, WAIT cycle 2, ACK cycle 3.
- Ack is high in the 3rd cycle after the sampling edge. Read data is valid on the port from the ack cycle until that port's next read ack.
- Minimum spacing between grants is 4 cycles (IDLE, ISSUE, WAIT, ACK).
- Back-to-back contention alternates ports. Worst-case wait for a port with req held is one foreign access: 8 cycles from req visible to ack.
- `o_busy` rises the cycle after a grant is taken and falls on entry to IDLE.
- `o_mem_en`/`o_mem_we` are high for exactly one cycle per access (ISSUE only).

## Test plan
- Reset: hold `i_rst_n`=0 for 3 cycles with both reqs high.
  - Required: all outputs 0 and no mem access during reset.
  - After release: SD granted first, with `o_mem_en` in the 2nd cycle after release.
- SD write then host read, same address: SD writes 0xA5 to 0x010; then host reads 0x010.
  - Required: `o_host_data`=0xA5 with `o_host_ack` 3 cycles after the host req is sampled.
  - Required: `o_sd_data` unchanged.
- Simultaneous contention: both ports request reads continuously for 6 accesses; RAM preloaded with address = data.
  - Required: grants alternate SD, host, SD, … with acks 4 cycles apart.
  - Required: each port's data equals its requested address [7:0].
- Write boundary: host writes 0xFF to address 0x1FF, then 0x00 to 0x000; SD reads both.
  - Required: SD reads 0xFF then 0x00. No address wrap or truncation.
- Reset mid-access:
  - Assert reset during WAIT of an SD write to 0x020 (data 0x3C).
  - Required: no `o_sd_ack`. A later host read of 0x020 returns 0x3C.
  - Repeat with reset asserted in the IDLE cycle before ISSUE. Required: the host read returns the old value.
- Write ack semantics: host reads 0x005 (value 0x11), then host writes 0x77 to 0x005.
  - Required: `o_host_data` stays 0x11 through the write ack. A subsequent read returns 0x77.
